pipeline_stall_sequencer: RTL and testbench

- Sequences the IF/ID front end of the 8-bit pipeline for the three multi-cycle control events: LOAD, JUMP and HALT.
- Decodes the instruction held in ID and drives the stall, program-memory stall, IF/ID flush and halt status.
- Uses an explicit FSM with parameterised stall lengths, so no event retriggers itself.
- Sits between the IF/ID register and the PC / program-memory enables.

---
 rtl/pipeline_stall_sequencer_pkg.sv | 22 ++
 rtl/stall_event_decode.sv | 23 ++
 rtl/pipeline_stall_sequencer.sv | 146 ++++++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and parameter limits for the IF/ID stall sequencer.
// Optional feature macro used by the top: STALL_PERF_CNT_EN.
package pipeline_stall_sequencer_pkg;

  localparam logic [4:0] OP_HALT     = 5'b10001;
  localparam logic [4:0] OP_LOAD     = 5'b10100;
  localparam logic [2:0] OP_JUMP_PFX = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN       = 3'd0;
  localparam state_t ST_LD_WAIT   = 3'd1;
  localparam state_t ST_JMP_FLUSH = 3'd2;
  localparam state_t ST_HALT      = 3'd3;
  localparam state_t ST_SKIP      = 3'd4;

  localparam int LD_STALL_MIN  = 1;
  localparam int LD_STALL_MAX  = 7;
  localparam int JMP_FLUSH_MIN = 1;
  localparam int JMP_FLUSH_MAX = 7;

endpackage

// File: rtl/stall_event_decode.sv
// Combinational decode of the ID-stage opcode into the three multi-cycle control events.
module stall_event_decode
  import pipeline_stall_sequencer_pkg::*;
(
  input  logic [23:0] i_ins,
  input  logic        i_ins_valid,
  output logic        o_is_ld,
  output logic        o_is_jmp,
  output logic        o_is_hlt
);

  logic [4:0] w_opcode;
  logic       w_unused_operand;

  assign w_opcode = i_ins[23:19];
  // Operand bits play no part in event classification.
  assign w_unused_operand = ^i_ins[18:0];

  assign o_is_ld  = i_ins_valid && (w_opcode == OP_LOAD);
  assign o_is_jmp = i_ins_valid && (w_opcode[4:2] == OP_JUMP_PFX);
  assign o_is_hlt = i_ins_valid && (w_opcode == OP_HALT);

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// IF/ID front-end sequencer for LOAD, JUMP and HALT stalls/flushes.
// Define STALL_PERF_CNT_EN to add the stall-cycle and jump-count performance counters.
module pipeline_stall_sequencer
  import pipeline_stall_sequencer_pkg::*;
#(
  parameter int LD_STALL_CYCLES  = 1,
  parameter int JMP_FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_ins,
  input  logic        i_ins_valid,
  input  logic        i_resume,
  output logic        o_stall,
  output logic        o_stall_pm,
  output logic        o_ifid_flush,
  output logic        o_halted
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [15:0] o_stall_cycles,
  output logic [7:0]  o_jmp_count
`endif
);

  if (LD_STALL_CYCLES < LD_STALL_MIN || LD_STALL_CYCLES > LD_STALL_MAX) begin : g_bad_ld
    $fatal(1, "LD_STALL_CYCLES out of range 1..7");
  end
  if (JMP_FLUSH_CYCLES < JMP_FLUSH_MIN || JMP_FLUSH_CYCLES > JMP_FLUSH_MAX) begin : g_bad_jmp
    $fatal(1, "JMP_FLUSH_CYCLES out of range 1..7");
  end

  localparam logic [2:0] LD_CNT_INIT  = 3'(LD_STALL_CYCLES - 1);
  localparam logic [2:0] JMP_CNT_INIT = 3'(JMP_FLUSH_CYCLES);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_stall_pm;
  state_t     w_next_state;
  logic [2:0] w_next_cnt;
  logic       w_stall;
  logic       w_flush;
  logic       w_halted;
  logic       w_jmp_det;
  logic       w_is_ld;
  logic       w_is_jmp;
  logic       w_is_hlt;

  stall_event_decode u_decode (
    .i_ins       (i_ins),
    .i_ins_valid (i_ins_valid),
    .o_is_ld     (w_is_ld),
    .o_is_jmp    (w_is_jmp),
    .o_is_hlt    (w_is_hlt)
  );

  // Event decode is honoured only in RUN; the detection cycle already stalls.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_halted     = 1'b0;
    w_jmp_det    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_is_ld) begin
          w_stall = 1'b1;
          if (LD_STALL_CYCLES == 1) begin
            w_next_state = ST_SKIP;
          end else begin
            w_next_state = ST_LD_WAIT;
            w_next_cnt   = LD_CNT_INIT;
          end
        end else if (w_is_jmp) begin
          w_stall      = 1'b1;
          w_jmp_det    = 1'b1;
          w_next_state = ST_JMP_FLUSH;
          w_next_cnt   = JMP_CNT_INIT;
        end else if (w_is_hlt) begin
          w_stall      = 1'b1;
          w_next_state = ST_HALT;
        end
      end
      ST_LD_WAIT: begin
        w_stall    = 1'b1;
        w_next_cnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_next_state = ST_SKIP;
      end
      ST_JMP_FLUSH: begin
        w_stall    = 1'b1;
        w_flush    = 1'b1;
        w_next_cnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_next_state = ST_RUN;
      end
      ST_HALT: begin
        w_stall  = 1'b1;
        w_halted = 1'b1;
        if (i_resume) w_next_state = ST_SKIP;
      end
      ST_SKIP: begin
        w_next_state = ST_RUN;
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_cnt      <= 3'd0;
      r_stall_pm <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_stall_pm <= w_stall;
    end
  end

  assign o_stall      = w_stall;
  assign o_stall_pm   = r_stall_pm;
  assign o_ifid_flush = w_flush;
  assign o_halted     = w_halted;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_jmp_count;

  // Both counters hold at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= 16'd0;
      r_jmp_count    <= 8'd0;
    end else begin
      if (w_stall && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_jmp_det && (r_jmp_count != 8'hFF)) r_jmp_count <= r_jmp_count + 8'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_jmp_count    = r_jmp_count;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench for pipeline_stall_sequencer: two instances (default and longer stalls) share stimulus.
// Build with STALL_PERF_CNT_EN defined to also check the performance counters.
module tb_pipeline_stall_sequencer;

  localparam int LD0  = 1;
  localparam int JMP0 = 2;
  localparam int LD1  = 3;
  localparam int JMP1 = 4;

  localparam logic [4:0] T_HALT = 5'b10001;
  localparam logic [4:0] T_LOAD = 5'b10100;

  typedef struct packed {
    logic stall;
    logic flush;
  } plan_t;

  typedef struct packed {
    logic        stall;
    logic        pm;
    logic        flush;
    logic        halted;
    logic [15:0] sc;
    logic [7:0]  jc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [23:0] ins;
  logic        insValid;
  logic        resume;
  logic        stall    [2];
  logic        stallPm  [2];
  logic        flush    [2];
  logic        halted   [2];
  logic [15:0] stallCyc [2];
  logic [7:0]  jmpCnt   [2];

  plan_t planQ [2][$];
  exp_t  expQ  [2][$];
  int    ldLen     [2];
  int    jmpLen    [2];
  bit    mHalt     [2];
  logic  prevStall [2];
  int    mStall    [2];
  int    mJmp      [2];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(.LD_STALL_CYCLES(LD0), .JMP_FLUSH_CYCLES(JMP0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_ins(ins), .i_ins_valid(insValid), .i_resume(resume),
    .o_stall(stall[0]), .o_stall_pm(stallPm[0]), .o_ifid_flush(flush[0]), .o_halted(halted[0])
`ifdef STALL_PERF_CNT_EN
    , .o_stall_cycles(stallCyc[0]), .o_jmp_count(jmpCnt[0])
`endif
  );

  pipeline_stall_sequencer #(.LD_STALL_CYCLES(LD1), .JMP_FLUSH_CYCLES(JMP1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_ins(ins), .i_ins_valid(insValid), .i_resume(resume),
    .o_stall(stall[1]), .o_stall_pm(stallPm[1]), .o_ifid_flush(flush[1]), .o_halted(halted[1])
`ifdef STALL_PERF_CNT_EN
    , .o_stall_cycles(stallCyc[1]), .o_jmp_count(jmpCnt[1])
`endif
  );

`ifndef STALL_PERF_CNT_EN
  initial begin
    stallCyc = '{16'd0, 16'd0};
    jmpCnt   = '{8'd0, 8'd0};
  end
`endif

  task automatic checkOutput(input string name, input int m, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual=%0h required=%0h at %0t", name, m, act, req, $time);
    end
  endtask

  function automatic logic [4:0] otherOp();
    logic [4:0] op;
    do op = 5'($urandom_range(0, 27)); while (op == T_HALT || op == T_LOAD);
    return op;
  endfunction

  function automatic logic [23:0] mkIns(input logic [4:0] op);
    return {op, 19'($urandom)};
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      planQ[m].delete();
      mHalt[m]     = 1'b0;
      prevStall[m] = 1'b0;
      mStall[m]    = 0;
      mJmp[m]      = 0;
    end
  endtask

  // Reference model: an event is an upfront schedule of per-cycle outputs; HALT is an open-ended hold.
  task automatic modelCycle(input int m, input logic [23:0] in, input logic v, input logic res, output exp_t e);
    plan_t p;
    logic [4:0] op = in[23:19];
    e = '0;
    e.sc = (mStall[m] > 65535) ? 16'hFFFF : 16'(mStall[m]);
    e.jc = (mJmp[m] > 255) ? 8'hFF : 8'(mJmp[m]);
    if (planQ[m].size() > 0) begin
      p = planQ[m].pop_front();
      e.stall = p.stall;
      e.flush = p.flush;
    end else if (mHalt[m]) begin
      e.stall  = 1'b1;
      e.halted = 1'b1;
      if (res) begin
        mHalt[m] = 1'b0;
        planQ[m].push_back(plan_t'(2'b00));
      end
    end else if (v && op == T_LOAD) begin
      e.stall = 1'b1;
      for (int k = 1; k < ldLen[m]; k++) planQ[m].push_back(plan_t'(2'b10));
      planQ[m].push_back(plan_t'(2'b00));
    end else if (v && op[4:2] == 3'b111) begin
      e.stall = 1'b1;
      for (int k = 0; k < jmpLen[m]; k++) planQ[m].push_back(plan_t'(2'b11));
      mJmp[m]++;
    end else if (v && op == T_HALT) begin
      e.stall  = 1'b1;
      mHalt[m] = 1'b1;
    end
    e.pm = prevStall[m];
    prevStall[m] = e.stall;
    if (e.stall) mStall[m]++;
  endtask

  task automatic applyStimulus(input logic [23:0] in, input logic v, input logic res);
    exp_t e;
    @(posedge clk);
    #1;
    ins      = in;
    insValid = v;
    resume   = res;
    for (int m = 0; m < 2; m++) begin
      modelCycle(m, in, v, res, e);
      expQ[m].push_back(e);
    end
  endtask

  task automatic checkQuiet(input string tag);
    for (int m = 0; m < 2; m++) begin
      checkOutput({tag, "_stall"}, m, 16'(stall[m]), 16'd0);
      checkOutput({tag, "_flush"}, m, 16'(flush[m]), 16'd0);
      checkOutput({tag, "_pm"}, m, 16'(stallPm[m]), 16'd0);
      checkOutput({tag, "_halted"}, m, 16'(halted[m]), 16'd0);
`ifdef STALL_PERF_CNT_EN
      checkOutput({tag, "_stallcyc"}, m, stallCyc[m], 16'd0);
      checkOutput({tag, "_jmpcnt"}, m, 16'(jmpCnt[m]), 16'd0);
`endif
    end
  endtask

  // Monitor: every falling edge the DUT presents one cycle of outputs per queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (expQ[m].size() > 0) begin
          e = expQ[m].pop_front();
          checkOutput("stall", m, 16'(stall[m]), 16'(e.stall));
          checkOutput("stall_pm", m, 16'(stallPm[m]), 16'(e.pm));
          checkOutput("ifid_flush", m, 16'(flush[m]), 16'(e.flush));
          checkOutput("halted", m, 16'(halted[m]), 16'(e.halted));
`ifdef STALL_PERF_CNT_EN
          checkOutput("stall_cycles", m, stallCyc[m], e.sc);
          checkOutput("jmp_count", m, 16'(jmpCnt[m]), 16'(e.jc));
`endif
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [23:0] cur;
    logic        curV;
    int          r;
    ldLen  = '{LD0, LD1};
    jmpLen = '{JMP0, JMP1};
    modelReset();
    rstN     = 1'b0;
    ins      = 24'd0;
    insValid = 1'b0;
    resume   = 1'b0;
    #12;
    checkQuiet("reset");
    rstN = 1'b1;

    // LOAD held two cycles, then bubbles while the longer instance finishes.
    applyStimulus(mkIns(T_LOAD), 1'b1, 1'b0);
    applyStimulus(mkIns(T_LOAD), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(mkIns(otherOp()), 1'b0, 1'b0);

    // JUMP with opcode 11101.
    applyStimulus(mkIns(5'b11101), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(mkIns(otherOp()), 1'b1, 1'b0);

    // HALT: resume on detection ignored, held 20 cycles, resume in cycle 20.
    for (int c = 0; c <= 21; c++) applyStimulus(mkIns(T_HALT), 1'b1, (c == 0 || c == 20));
    for (int i = 0; i < 3; i++) applyStimulus(mkIns(otherOp()), 1'b1, 1'b0);

    // Asynchronous reset in the middle of JMP_FLUSH.
    applyStimulus(mkIns(5'b11110), 1'b1, 1'b0);
    applyStimulus(mkIns(otherOp()), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    for (int m = 0; m < 2; m++) checkOutput("preflush", m, 16'(flush[m]), 16'd1);
    rstN = 1'b0;
    #1;
    checkQuiet("midreset");
    modelReset();
    @(negedge clk);
    #2;
    rstN = 1'b1;

    // Two JUMPs and one LOAD after reset.
    applyStimulus(mkIns(5'b11100), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(24'd0, 1'b0, 1'b0);
    applyStimulus(mkIns(5'b11111), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(24'd0, 1'b0, 1'b0);
    applyStimulus(mkIns(T_LOAD), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(24'd0, 1'b0, 1'b0);

    // Randomised traffic with repeated instructions and stray resume pulses.
    cur  = 24'd0;
    curV = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 99);
        if (r < 15)      cur = mkIns(T_LOAD);
        else if (r < 30) cur = mkIns({3'b111, 2'($urandom)});
        else if (r < 38) cur = mkIns(T_HALT);
        else             cur = mkIns(otherOp());
        curV = ($urandom_range(0, 99) < 85);
      end
      applyStimulus(cur, curV, ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (expQ[m].size() != 0) begin
        errors++;
        $display("[TB] FAIL drain dut%0d actual=%0d required=0 pending", m, expQ[m].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
